// File: rtl/validar_hex_fifo.sv
// validar_hex_fifo: PS/2 set-2 hex-key decoder feeding a DEPTH-entry FIFO.
// Break (F0 xx) and extended (E0 xx) sequences are filtered by a small FSM.
// Rejected keys and FIFO overflows set a sticky Led_Invalid indicator.
// Optional feature macro: VALIDAR_STATS_EN enables the saturating Invalid_Count.
// Without the macro, Invalid_Count is tied to zero.
module validar_hex_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk_V,
  input  logic             Reset_V,
  input  logic [7:0]       Save_KeyCode,
  input  logic             KeyCode_Stb,
  input  logic             Valid_Pop,
  output logic [7:0]       Valid_KeyCode,
  output logic [3:0]       Valid_Nibble,
  output logic             Valid_Avail,
  output logic             Fifo_Full,
  output logic             Led_Invalid,
  output logic [CNT_W-1:0] Invalid_Count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned ENTRY_W = 12;
  localparam logic [7:0]  BREAK_CODE = 8'hF0;
  localparam logic [7:0]  EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_EXT   = 2'd2
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic                 r_led;

  logic                 w_hit;
  logic [3:0]           w_nib;
  logic                 w_is_break;
  logic                 w_is_ext;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bad_key;
  logic                 w_event;
  logic [ENTRY_W-1:0]   w_head;

  // Scan-code set 2 make code to hex nibble lookup
  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (Save_KeyCode)
      8'h45: w_nib = 4'h0;
      8'h16: w_nib = 4'h1;
      8'h1E: w_nib = 4'h2;
      8'h26: w_nib = 4'h3;
      8'h25: w_nib = 4'h4;
      8'h2E: w_nib = 4'h5;
      8'h36: w_nib = 4'h6;
      8'h3D: w_nib = 4'h7;
      8'h3E: w_nib = 4'h8;
      8'h46: w_nib = 4'h9;
      8'h1C: w_nib = 4'hA;
      8'h32: w_nib = 4'hB;
      8'h21: w_nib = 4'hC;
      8'h23: w_nib = 4'hD;
      8'h24: w_nib = 4'hE;
      8'h2B: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  assign w_is_break = (Save_KeyCode == BREAK_CODE);
  assign w_is_ext   = (Save_KeyCode == EXT_CODE);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_req = KeyCode_Stb && (r_state == ST_IDLE) && w_hit;
  assign w_push     = w_push_req && (!w_full || Valid_Pop);
  assign w_pop      = Valid_Pop && !w_empty;

  assign w_bad_key = KeyCode_Stb &&
                     (((r_state == ST_IDLE) && !w_hit && !w_is_break && !w_is_ext) ||
                      ((r_state == ST_EXT) && !w_is_break));
  assign w_event   = w_bad_key || (w_push_req && !w_push);

  // Prefix-tracking FSM; only advances on a strobe
  always_ff @(posedge Clk_V or negedge Reset_V) begin
    if (!Reset_V) begin
      r_state <= ST_IDLE;
    end else if (KeyCode_Stb) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_break)    r_state <= ST_BREAK;
          else if (w_is_ext) r_state <= ST_EXT;
          else               r_state <= ST_IDLE;
        end
        ST_BREAK: r_state <= ST_IDLE;
        ST_EXT: begin
          if (w_is_break) r_state <= ST_BREAK;
          else            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers; one extra bit distinguishes full from empty
  always_ff @(posedge Clk_V or negedge Reset_V) begin
    if (!Reset_V) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written, head is masked when empty
  always_ff @(posedge Clk_V) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {Save_KeyCode, w_nib};
  end

  // Sticky invalid indicator; a new event takes priority over a clearing push
  always_ff @(posedge Clk_V or negedge Reset_V) begin
    if (!Reset_V)     r_led <= 1'b0;
    else if (w_event) r_led <= 1'b1;
    else if (w_push)  r_led <= 1'b0;
  end

`ifdef VALIDAR_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of invalid and overflow events
  always_ff @(posedge Clk_V or negedge Reset_V) begin
    if (!Reset_V)                       r_cnt <= '0;
    else if (w_event && (r_cnt != '1))  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign Invalid_Count = r_cnt;
`else
  assign Invalid_Count = '0;
`endif

  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign Valid_KeyCode = w_empty ? 8'h00 : w_head[11:4];
  assign Valid_Nibble  = w_empty ? 4'h0  : w_head[3:0];
  assign Valid_Avail   = !w_empty;
  assign Fifo_Full     = w_full;
  assign Led_Invalid   = r_led;

endmodule

// File: tb/tb_validar_hex_fifo.sv
// Scoreboard bench for validar_hex_fifo (DEPTH=4, CNT_W=4).
// Expected entries are queued at stimulus time; a negedge monitor pops and
// compares the FIFO head whenever the DUT pops an entry.
module tb_validar_hex_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             Clk_V;
  logic             Reset_V;
  logic [7:0]       Save_KeyCode;
  logic             KeyCode_Stb;
  logic             Valid_Pop;
  logic [7:0]       Valid_KeyCode;
  logic [3:0]       Valid_Nibble;
  logic             Valid_Avail;
  logic             Fifo_Full;
  logic             Led_Invalid;
  logic [CNT_W-1:0] Invalid_Count;

  int checks;
  int failures;
  int exp_ev;
  logic [11:0] exp_q[$];

  validar_hex_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk_V        (Clk_V),
    .Reset_V      (Reset_V),
    .Save_KeyCode (Save_KeyCode),
    .KeyCode_Stb  (KeyCode_Stb),
    .Valid_Pop    (Valid_Pop),
    .Valid_KeyCode(Valid_KeyCode),
    .Valid_Nibble (Valid_Nibble),
    .Valid_Avail  (Valid_Avail),
    .Fifo_Full    (Fifo_Full),
    .Led_Invalid  (Led_Invalid),
    .Invalid_Count(Invalid_Count)
  );

  initial Clk_V = 1'b0;
  always #5 Clk_V = ~Clk_V;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int ev);
`ifdef VALIDAR_STATS_EN
    int mx;
    mx = (1 << CNT_W) - 1;
    return (ev > mx) ? mx : ev;
`else
    return 0;
`endif
  endfunction

  // Monitor: whenever the consumer takes the head, compare against the scoreboard
  always @(negedge Clk_V) begin
    if (Reset_V && Valid_Pop && Valid_Avail) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h with no expected entry", Valid_KeyCode);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("head_code", int'(Valid_KeyCode), int'(e[11:4]));
        chk("head_nib", int'(Valid_Nibble), int'(e[3:0]));
      end
    end
  end

  // One cycle of stimulus; inputs change 1 time unit after the rising edge
  task automatic drive(input logic stb, input logic [7:0] code, input logic pop);
    KeyCode_Stb  = stb;
    Save_KeyCode = code;
    Valid_Pop    = pop;
    @(posedge Clk_V);
    #1;
    KeyCode_Stb = 1'b0;
    Valid_Pop   = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] code, input logic pop, input logic push,
                        input logic [3:0] nib);
    if (push) exp_q.push_back({code, nib});
    drive(1'b1, code, pop);
  endtask

  task automatic pop_one();
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_avail"}, int'(Valid_Avail), 0);
    chk({tag, "_full"}, int'(Fifo_Full), 0);
    chk({tag, "_code"}, int'(Valid_KeyCode), 0);
    chk({tag, "_nib"}, int'(Valid_Nibble), 0);
    chk({tag, "_led"}, int'(Led_Invalid), 0);
    chk({tag, "_cnt"}, int'(Invalid_Count), 0);
  endtask

  initial begin
    checks = 0; failures = 0; exp_ev = 0;
    Reset_V = 1'b0; Save_KeyCode = 8'h00; KeyCode_Stb = 1'b0; Valid_Pop = 1'b0;
    repeat (2) @(posedge Clk_V);
    #1;
    chk_reset_outputs("rst");
    Reset_V = 1'b1;
    @(posedge Clk_V); #1;

    // Single key B
    strobe(8'h32, 1'b0, 1'b1, 4'hB);
    chk("b_avail", int'(Valid_Avail), 1);
    chk("b_code", int'(Valid_KeyCode), 'h32);
    chk("b_nib", int'(Valid_Nibble), 'hB);
    chk("b_led", int'(Led_Invalid), 0);
    pop_one();
    chk("b_empty_avail", int'(Valid_Avail), 0);
    chk("b_empty_code", int'(Valid_KeyCode), 0);

    // Make, break, released key: only one entry
    strobe(8'h24, 1'b0, 1'b1, 4'hE);
    strobe(8'hF0, 1'b0, 1'b0, 4'h0);
    strobe(8'h24, 1'b0, 1'b0, 4'h0);
    chk("brk_code", int'(Valid_KeyCode), 'h24);
    chk("brk_led", int'(Led_Invalid), 0);
    pop_one();
    chk("brk_one_entry", int'(Valid_Avail), 0);

    // Ignored strobe-less byte and pop while empty
    drive(1'b0, 8'h16, 1'b1);
    chk("nostb_avail", int'(Valid_Avail), 0);

    // Invalid key then a valid key clears the indicator
    strobe(8'h1A, 1'b0, 1'b0, 4'h0); exp_ev++;
    chk("inv_led", int'(Led_Invalid), 1);
    chk("inv_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    strobe(8'h16, 1'b0, 1'b1, 4'h1);
    chk("clr_led", int'(Led_Invalid), 0);
    chk("clr_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    chk("clr_nib", int'(Valid_Nibble), 1);
    pop_one();

    // Fill to DEPTH, overflow, then push with simultaneous pop
    strobe(8'h16, 1'b0, 1'b1, 4'h1);
    strobe(8'h1E, 1'b0, 1'b1, 4'h2);
    strobe(8'h26, 1'b0, 1'b1, 4'h3);
    chk("fill3_full", int'(Fifo_Full), 0);
    strobe(8'h25, 1'b0, 1'b1, 4'h4);
    chk("fill4_full", int'(Fifo_Full), 1);
    strobe(8'h2E, 1'b0, 1'b0, 4'h0); exp_ev++;
    chk("ovf_led", int'(Led_Invalid), 1);
    chk("ovf_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    chk("ovf_full", int'(Fifo_Full), 1);
    chk("ovf_head", int'(Valid_KeyCode), 'h16);
    strobe(8'h2E, 1'b1, 1'b1, 4'h5);
    chk("pp_full", int'(Fifo_Full), 1);
    chk("pp_head", int'(Valid_KeyCode), 'h1E);
    chk("pp_nib", int'(Valid_Nibble), 2);
    chk("pp_led", int'(Led_Invalid), 0);
    repeat (4) pop_one();
    chk("drain_avail", int'(Valid_Avail), 0);
    chk("drain_full", int'(Fifo_Full), 0);

    // Extended prefix handling
    strobe(8'hE0, 1'b0, 1'b0, 4'h0);
    strobe(8'h75, 1'b0, 1'b0, 4'h0); exp_ev++;
    chk("ext_led", int'(Led_Invalid), 1);
    chk("ext_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    chk("ext_avail", int'(Valid_Avail), 0);
    strobe(8'hE0, 1'b0, 1'b0, 4'h0);
    strobe(8'hF0, 1'b0, 1'b0, 4'h0);
    strobe(8'h75, 1'b0, 1'b0, 4'h0);
    chk("extbrk_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    chk("extbrk_avail", int'(Valid_Avail), 0);
    strobe(8'h45, 1'b0, 1'b1, 4'h0);
    chk("idle_code", int'(Valid_KeyCode), 'h45);
    chk("idle_led", int'(Led_Invalid), 0);
    pop_one();

    // Saturation of the event counter
    for (int i = 0; i < 20; i++) begin
      strobe(8'h1A, 1'b0, 1'b0, 4'h0);
      exp_ev++;
    end
    chk("sat_cnt", int'(Invalid_Count), exp_cnt(exp_ev));
    chk("sat_led", int'(Led_Invalid), 1);

    // Asynchronous reset while in BREAK with data in the FIFO
    strobe(8'h16, 1'b0, 1'b1, 4'h1);
    strobe(8'hF0, 1'b0, 1'b0, 4'h0);
    chk("pre_rst_avail", int'(Valid_Avail), 1);
    #2;
    Reset_V = 1'b0;
    #1;
    chk_reset_outputs("arst");
    exp_q.delete();
    @(posedge Clk_V); #1;
    Reset_V = 1'b1;
    strobe(8'h16, 1'b0, 1'b1, 4'h1);
    chk("post_rst_code", int'(Valid_KeyCode), 'h16);
    pop_one();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/validar_hex_fifo.md
# validar_hex_fifo

Parametrised successor to the keycode validator. Accepts PS/2 scan-code set 2 bytes from the keyboard receiver and decodes make codes for hex keys 0–9 and A–F. Valid keys are pushed into a DEPTH-entry FIFO for the downstream consumer; rejected keys raise an invalid indicator. An FSM discards break sequences (F0 xx) and extended sequences (E0 xx).

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNT_W, 4, width of invalid-event counter
- Clk_V  in  1  system clock, rising edge
- Reset_V  in  1  asynchronous, active-low reset
- Save_KeyCode  in  8  scan-code byte from the receiver
- KeyCode_Stb  in  1  one-cycle strobe; Save_KeyCode is valid in this cycle
- Valid_Pop  in  1  consumer takes the head entry this cycle
- Valid_KeyCode  out  8  raw make code at the FIFO head (00 when empty)
- Valid_Nibble  out  4  hex value of the head entry (0 when empty)
- Valid_Avail  out  1  FIFO not empty
- Fifo_Full  out  1  FIFO holds DEPTH entries
- Led_Invalid  out  1  sticky invalid/overflow indicator
- Invalid_Count  out  CNT_W  saturating count of invalid and overflow events

## Operation
- Decode table (code -> nibble):
  - 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9
  - 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F
- Every other byte, except the prefixes F0 and E0, is invalid.
- FSM states, all transitions on KeyCode_Stb only:
  - IDLE
    - F0 -> BREAK
    - E0 -> EXT
    - table hit -> push, stay IDLE
    - other -> invalid event, stay IDLE
  - BREAK: any byte is discarded silently -> IDLE
  - EXT
    - F0 -> BREAK
    - any other byte -> invalid event -> IDLE
- Push:
  - Writes {code, nibble} at the write pointer.
  - Accepted when the FIFO is not full, or when it is full and Valid_Pop is high in the same cycle.
  - Otherwise the byte is dropped and counted as an overflow event.
- Pop: Valid_Pop while Valid_Avail advances the read pointer. Valid_Pop while empty is ignored.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Empty: pointers are equal.
  - Full: MSBs differ and the remaining bits are equal.
- Led_Invalid:
  - Set by an invalid or overflow event.
  - Cleared by the next accepted push.
  - If both happen in one cycle, set wins. This can only occur across two separate strobes, so the rule is for completeness.
- Invalid_Count increments by 1 per event and saturates at 2^CNT_W−1 with no wrap.

## Timing
- Reset (Reset_V low, asynchronous):
  - FSM to IDLE, pointers to 0
  - Valid_Avail=0, Fifo_Full=0, Valid_KeyCode=00, Valid_Nibble=0
  - Led_Invalid=0, Invalid_Count=0
- Reset mid-sequence (e.g. in BREAK) returns to IDLE. FIFO contents are lost.
- Strobe in cycle N:
  - FSM, FIFO, Led_Invalid and Invalid_Count update at the rising edge ending cycle N.
  - Valid_Avail is high from N+1.
- Head outputs:
  - Driven from registered storage via the read pointer, with no extra cycle.
  - After a pop at edge N, the next entry appears in N+1.
- Back-to-back strobes on consecutive cycles are supported.
- Bytes arriving while KeyCode_Stb is low are ignored.

## Configuration
- VALIDAR_STATS_EN defined: Invalid_Count is implemented as specified.
- VALIDAR_STATS_EN undefined:
  - No counter is implemented; Invalid_Count is tied to 0.
  - Led_Invalid behaviour is unchanged.

## Test plan
- Reset, then strobe 32 -> Valid_Avail=1, Valid_KeyCode=32, Valid_Nibble=B, Led_Invalid=0. Pop -> Valid_Avail=0, Valid_KeyCode=00.
- Strobe 24, F0, 24 -> exactly one entry (24, nibble E). The byte after F0 is discarded and Led_Invalid stays 0.
- Strobe 1A -> Led_Invalid=1, Invalid_Count=1. Then strobe 16 -> entry nibble 1, Led_Invalid=0, Invalid_Count stays 1.
- DEPTH=4: strobe 16,1E,26,25 with no pop -> Fifo_Full=1.
  - Strobe 2E -> dropped, Led_Invalid=1, count+1.
  - Strobe 2E with Valid_Pop the same cycle -> accepted, Fifo_Full stays 1, head becomes 1E.
- Strobe E0, 75 -> invalid event, no push. Strobe E0, F0, 75 -> no push, no event, FSM back in IDLE.
- Drive 20 invalid strobes with CNT_W=4 -> Invalid_Count saturates at F.
  - Assert Reset_V low mid-stream (FSM in BREAK) -> all outputs return to their reset values immediately.
